// File: rtl/ethertype_classifier.sv
// EtherType classifier and payload gate for an N-bit-per-cycle receive stream.
// Define ETHERTYPE_VLAN_EN to strip one 802.1Q tag and classify the inner type.
module ethertype_classifier #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] axiid,
    input  logic         axiiv,
    output logic [N-1:0] axiod,
    output logic         axiov,
    output logic [1:0]   cls,
    output logic         clsv,
    output logic         vlan,
    output logic [11:0]  vid,
    output logic         done
);

    localparam int CHUNKS = 16 / N;
    localparam int CW = $clog2(CHUNKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [2:0] {
        S_TYPE,
        S_PAYLOAD,
        S_DROP
`ifdef ETHERTYPE_VLAN_EN
        , S_TAG,
        S_TYPE2
`endif
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  count;
    logic [15:0]    shift;
    logic [15:0]    field;
    logic           last;
    logic           header;
    logic           clsv_set;
    logic [1:0]     cls_next;
`ifdef ETHERTYPE_VLAN_EN
    logic           tagged_next;
    logic           tci_latch;
    logic [11:0]    vid_pend;
`endif

    function automatic logic [1:0] type_class(input logic [15:0] t);
        case (t)
            16'h0800: type_class = 2'd1;
            16'h0806: type_class = 2'd2;
            16'h86DD: type_class = 2'd3;
            default:  type_class = 2'd0;
        endcase
    endfunction

    // The field as it will look once the current chunk is shifted in.
    assign field  = 16'({shift, axiid});
    assign last   = axiiv && (count == LAST);
    assign header = (state != S_PAYLOAD) && (state != S_DROP);

    always_comb begin
        state_next = state;
        clsv_set   = 1'b0;
        cls_next   = 2'd0;
`ifdef ETHERTYPE_VLAN_EN
        tagged_next = 1'b0;
        tci_latch   = 1'b0;
`endif
        case (state)
            S_TYPE: begin
                if (last) begin
`ifdef ETHERTYPE_VLAN_EN
                    if (field == 16'h8100) begin
                        state_next = S_TAG;
                    end else
`endif
                    begin
                        clsv_set   = 1'b1;
                        cls_next   = type_class(field);
                        state_next = (cls_next != 2'd0) ? S_PAYLOAD : S_DROP;
                    end
                end
            end
`ifdef ETHERTYPE_VLAN_EN
            S_TAG: begin
                if (!axiiv) begin
                    state_next = S_TYPE;
                end else if (last) begin
                    tci_latch  = 1'b1;
                    state_next = S_TYPE2;
                end
            end
            S_TYPE2: begin
                if (!axiiv) begin
                    state_next = S_TYPE;
                end else if (last) begin
                    clsv_set    = 1'b1;
                    tagged_next = 1'b1;
                    cls_next    = type_class(field);
                    state_next  = (cls_next != 2'd0) ? S_PAYLOAD : S_DROP;
                end
            end
`endif
            S_PAYLOAD, S_DROP: begin
                if (!axiiv) state_next = S_TYPE;
            end
            default: state_next = S_TYPE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_TYPE;
            count <= '0;
            shift <= '0;
            axiod <= '0;
            axiov <= 1'b0;
            cls   <= 2'd0;
            clsv  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            // A gap in the header or a completed field restarts collection.
            if (header && axiiv && !last) begin
                count <= count + CW'(1);
                shift <= field;
            end else begin
                count <= '0;
                shift <= '0;
            end
            axiov <= axiiv && (state == S_PAYLOAD);
            axiod <= (axiiv && (state == S_PAYLOAD)) ? axiid : '0;
            clsv  <= clsv_set;
            if (clsv_set) cls <= cls_next;
            done  <= !axiiv && ((state == S_PAYLOAD) || (state == S_DROP));
        end
    end

`ifdef ETHERTYPE_VLAN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vlan     <= 1'b0;
            vid      <= '0;
            vid_pend <= '0;
        end else begin
            if (tci_latch) vid_pend <= field[11:0];
            if (clsv_set) begin
                vlan <= tagged_next;
                vid  <= tagged_next ? vid_pend : 12'd0;
            end
        end
    end
`else
    assign vlan = 1'b0;
    assign vid  = 12'd0;
`endif

endmodule

// File: tb/tb_ethertype_classifier.sv
// Bench for ethertype_classifier: a timeline of directed and random frames is built up front,
// a frame-level model derives every expected output per cycle, and one process compares each cycle.
module tb_ethertype_classifier;

    localparam int N = 2;
    localparam int H = 16 / N;
    localparam int MAXC = 4096;
`ifdef ETHERTYPE_VLAN_EN
    localparam bit VLAN = 1'b1;
`else
    localparam bit VLAN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         axiiv;
    logic [N-1:0] axiid;
    logic [N-1:0] axiod;
    logic         axiov;
    logic [1:0]   cls;
    logic         clsv;
    logic         vlan;
    logic [11:0]  vid;
    logic         done;

    always #5 clk = ~clk;

    ethertype_classifier #(.N(N)) dut (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
        .axiod(axiod), .axiov(axiov), .cls(cls), .clsv(clsv),
        .vlan(vlan), .vid(vid), .done(done)
    );

    // Stimulus timeline and expected per-cycle outputs (index = output cycle label).
    logic         in_v   [MAXC];
    logic [N-1:0] in_d   [MAXC];
    logic         in_rst [MAXC];
    logic         e_v    [MAXC];
    logic [N-1:0] e_d    [MAXC];
    logic         e_clsv [MAXC];
    logic         e_done [MAXC];
    logic [1:0]   ev_cls [MAXC];
    logic         ev_vlan[MAXC];
    logic [11:0]  ev_vid [MAXC];

    int tp;
    int end_cyc;
    int n_checks = 0;
    int n_fail = 0;
    int pin_v4 = -1, pin_vlan = -1, pin_rst = -1, pin_zero = -1, pin_trunc = -1, pin_dbl = -1;

    task automatic add_word(input logic [15:0] w);
        for (int j = 0; j < H; j++) begin
            in_v[tp] = 1'b1;
            in_d[tp] = N'(w >> (16 - N * (j + 1)));
            tp++;
        end
    endtask

    task automatic add_partial(input logic [15:0] w, input int n);
        for (int j = 0; j < n; j++) begin
            in_v[tp] = 1'b1;
            in_d[tp] = N'(w >> (16 - N * (j + 1)));
            tp++;
        end
    endtask

    task automatic add_payload(input int n);
        for (int j = 0; j < n; j++) begin
            in_v[tp] = 1'b1;
            in_d[tp] = N'($urandom);
            tp++;
        end
    endtask

    task automatic add_idle(input int n);
        tp += n;
    endtask

    function automatic logic [1:0] class_of(input logic [15:0] t);
        if (t == 16'h0800) return 2'd1;
        if (t == 16'h0806) return 2'd2;
        if (t == 16'h86DD) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [15:0] field_at(input int s);
        logic [15:0] f = 16'h0;
        for (int j = 0; j < H; j++) f = (f << N) | 16'(in_d[s + j]);
        return f;
    endfunction

    // One frame = chunks s..s+len-1; ended_low means axiiv dropped (rather than a reset) afterwards.
    task automatic model_frame(input int s, input int len, input bit ended_low);
        int hdr;
        logic [1:0] c;
        logic tag;
        logic [11:0] v;
        logic [15:0] t;
        if (len < H) return;
        t = field_at(s);
        if (VLAN && t == 16'h8100) begin
            if (len < 3 * H) return;
            tag = 1'b1;
            v = field_at(s + H) & 16'h0FFF;
            c = class_of(field_at(s + 2 * H));
            hdr = 3 * H;
        end else begin
            tag = 1'b0;
            v = 12'h0;
            c = class_of(t);
            hdr = H;
        end
        e_clsv[s + hdr] = 1'b1;
        ev_cls[s + hdr] = c;
        ev_vlan[s + hdr] = tag;
        ev_vid[s + hdr] = v;
        if (c != 2'd0) begin
            for (int k = hdr; k < len; k++) begin
                e_v[s + k + 1] = 1'b1;
                e_d[s + k + 1] = in_d[s + k];
            end
        end
        if (ended_low) e_done[s + len + 1] = 1'b1;
    endtask

    task automatic build_model();
        int c = 0;
        int s;
        while (c < tp) begin
            if (in_v[c] && !in_rst[c]) begin
                s = c;
                while (in_v[c] && !in_rst[c]) c++;
                model_frame(s, c - s, !in_v[c]);
            end else begin
                c++;
            end
        end
        // A reset cycle forces every output to zero on the following cycle.
        for (int r = 0; r < tp; r++) begin
            if (in_rst[r]) begin
                e_v[r + 1] = 1'b0;
                e_clsv[r + 1] = 1'b0;
                e_done[r + 1] = 1'b0;
            end
        end
    endtask

    task automatic build_stimulus();
        int pick;
        logic [15:0] w;
        for (int i = 0; i < MAXC; i++) begin
            in_v[i] = 1'b0; in_d[i] = '0; in_rst[i] = 1'b0;
            e_v[i] = 1'b0; e_d[i] = '0; e_clsv[i] = 1'b0; e_done[i] = 1'b0;
            ev_cls[i] = 2'd0; ev_vlan[i] = 1'b0; ev_vid[i] = 12'h0;
        end
        tp = 0;
        in_rst[0] = 1'b1;
        in_rst[1] = 1'b1;
        add_idle(3);
        // IPv4, 8 payload chunks
        pin_v4 = tp + H;
        add_word(16'h0800); add_payload(8); add_idle(1);
        // ARP then LLDP (unknown), one idle between
        add_word(16'h0806); add_payload(5); add_idle(1);
        add_word(16'h88CC); add_payload(4); add_idle(2);
        // tagged IPv6, vid 0x064
        pin_vlan = tp + (VLAN ? 3 * H : H);
        add_word(16'h8100); add_word(16'h2064); add_word(16'h86DD); add_payload(3); add_idle(2);
        // truncated header, then a clean IPv4
        add_partial(16'h0800, H / 2); add_idle(1);
        pin_trunc = tp + H;
        add_word(16'h0800); add_payload(3); add_idle(1);
        // reset during payload; the leftover chunks are too short to form a header
        add_word(16'h0800); add_payload(3);
        in_rst[tp] = 1'b1;
        pin_rst = tp + 1;
        add_payload(1); add_payload(H - 1); add_idle(2);
        add_word(16'h0806); add_payload(2); add_idle(1);
        // double tag
        pin_dbl = tp + (VLAN ? 3 * H : H);
        add_word(16'h8100); add_word(16'h0ABC); add_word(16'h8100); add_payload(3); add_idle(1);
        // zero-payload frame, immediately followed (one idle) by another
        pin_zero = tp + H + 1;
        add_word(16'h86DD); add_idle(1);
        add_word(16'h0806); add_payload(2); add_idle(1);
        // random frames
        while (tp < MAXC - 120) begin
            pick = $urandom_range(0, 6);
            case (pick)
                0: add_word(16'h0800);
                1: add_word(16'h0806);
                2: add_word(16'h86DD);
                3: add_word(16'($urandom));
                4: begin
                    add_word(16'h8100);
                    add_word(16'($urandom));
                    w = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h86DD;
                    add_word(w);
                end
                5: begin add_word(16'h8100); add_word(16'($urandom)); add_word(16'h8100); end
                default: add_payload($urandom_range(1, 2 * H));
            endcase
            add_payload($urandom_range(0, 10));
            add_idle($urandom_range(1, 3));
        end
        add_idle(4);
        end_cyc = tp;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    initial begin
        build_stimulus();
        build_model();
        for (int c = 0; c < end_cyc; c++) begin
            axiiv = in_v[c];
            axiid = in_d[c];
            rst = in_rst[c];
            @(posedge clk);
            #1;
        end
    end

    initial begin
        logic [1:0] cur_cls = 2'd0;
        logic cur_vlan = 1'b0;
        logic [11:0] cur_vid = 12'h0;
        @(posedge clk);
        for (int c = 1; c < end_cyc; c++) begin
            @(negedge clk);
            if (in_rst[c - 1]) begin
                cur_cls = 2'd0; cur_vlan = 1'b0; cur_vid = 12'h0;
            end else if (e_clsv[c]) begin
                cur_cls = ev_cls[c]; cur_vlan = ev_vlan[c]; cur_vid = ev_vid[c];
            end
            chk("axiov", c, 32'(axiov), 32'(e_v[c]));
            if (e_v[c]) chk("axiod", c, 32'(axiod), 32'(e_d[c]));
            chk("clsv", c, 32'(clsv), 32'(e_clsv[c]));
            chk("done", c, 32'(done), 32'(e_done[c]));
            chk("cls", c, 32'(cls), 32'(cur_cls));
            chk("vlan", c, 32'(vlan), 32'(cur_vlan));
            chk("vid", c, 32'(vid), 32'(cur_vid));
            if (c == 2) begin
                chk("reset_cls", c, 32'(cls), 32'd0);
                chk("reset_axiov", c, 32'(axiov), 32'd0);
            end
            if (c == pin_v4) begin
                chk("pin_v4_clsv", c, 32'(clsv), 32'd1);
                chk("pin_v4_cls", c, 32'(cls), 32'd1);
            end
            if (c == pin_vlan) begin
                chk("pin_vlan_clsv", c, 32'(clsv), 32'd1);
                chk("pin_vlan_cls", c, 32'(cls), VLAN ? 32'd3 : 32'd0);
                chk("pin_vlan_flag", c, 32'(vlan), VLAN ? 32'd1 : 32'd0);
                chk("pin_vlan_vid", c, 32'(vid), VLAN ? 32'h064 : 32'h0);
            end
            if (c == pin_trunc) chk("pin_trunc_cls", c, 32'(cls), 32'd1);
            if (c == pin_rst) begin
                chk("pin_rst_cls", c, 32'(cls), 32'd0);
                chk("pin_rst_axiov", c, 32'(axiov), 32'd0);
            end
            if (c == pin_dbl) begin
                chk("pin_dbl_cls", c, 32'(cls), 32'd0);
                chk("pin_dbl_vlan", c, 32'(vlan), VLAN ? 32'd1 : 32'd0);
            end
            if (c == pin_zero) begin
                chk("pin_zero_done", c, 32'(done), 32'd1);
                chk("pin_zero_axiov", c, 32'(axiov), 32'd0);
            end
            @(posedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
